// File: rtl/avs_sdram_responder.sv
// Avalon-MM slave standing in for the SDRAM controller: word array with wait-state and read-latency timing.
// Optional AVS_PIPELINED_READ_EN: reads complete in ACCEPT and return through a READ_LATENCY-deep pipeline.
module avs_sdram_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] avs_s0_address,
  input  logic        avs_s0_read_n,
  input  logic        avs_s0_write_n,
  input  logic [31:0] avs_s0_writedata,
  output logic        avs_s0_waitrequest,
  output logic [31:0] avs_s0_readdata,
`ifdef AVS_PIPELINED_READ_EN
  output logic        avs_s0_readdatavalid,
`endif
  output logic        protocol_error,
  output logic [7:0]  status
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_LAT    = 2'd2,
    S_ACCEPT = 2'd3
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] LAT_INIT  = (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

`ifdef AVS_PIPELINED_READ_EN
  localparam bit PIPELINED = 1'b1;
`else
  localparam bit PIPELINED = 1'b0;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  logic cmd_valid, cmd_write, cmd_read, read_needs_lat;
  logic accept_wr, accept_rd;
  logic pipe_busy;

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_rdata;
  logic                  unused_addr_bits;

  assign cmd_valid      = ~avs_s0_read_n | ~avs_s0_write_n;
  assign cmd_write      = ~avs_s0_write_n;
  assign cmd_read       = cmd_valid & ~cmd_write;
  assign read_needs_lat = cmd_read & ~PIPELINED;

  // High address bits are dropped on purpose so the array aliases.
  assign mem_addr         = avs_s0_address[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^avs_s0_address[24:DEPTH_LOG2];
  assign mem_rdata        = mem[mem_addr];

  assign accept_wr = (state_reg == S_ACCEPT) & cmd_write;
  assign accept_rd = (state_reg == S_ACCEPT) & cmd_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg | (~avs_s0_read_n & ~avs_s0_write_n);
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          if (WAIT_CYCLES != 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end else if (read_needs_lat) begin
            // Keeps the read at WAIT_CYCLES+1+READ_LATENCY wait cycles even with no wait states.
            state_next = S_LAT;
            cnt_next   = LAT_INIT;
          end else begin
            state_next = S_ACCEPT;
          end
        end
      end
      S_WAIT: begin
        if (!cmd_valid) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (read_needs_lat) begin
          state_next = S_LAT;
          cnt_next   = LAT_INIT;
        end else begin
          state_next = S_ACCEPT;
        end
      end
      S_LAT: begin
        if (!cmd_valid) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        if (!cmd_valid) err_next = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept_wr) mem[mem_addr] <= avs_s0_writedata;
  end

`ifdef AVS_PIPELINED_READ_EN
  logic        pipe_valid_reg [READ_LATENCY];
  logic [31:0] pipe_data_reg  [READ_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      logic        v_in;
      logic [31:0] d_in;
      if (gi == 0) begin : g_head
        assign v_in = accept_rd;
        assign d_in = mem_rdata;
      end else begin : g_tail
        assign v_in = pipe_valid_reg[gi-1];
        assign d_in = pipe_data_reg[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_valid_reg[gi] <= 1'b0;
        else       pipe_valid_reg[gi] <= v_in;
      end

      always_ff @(posedge clk) begin
        pipe_data_reg[gi] <= d_in;
      end
    end
  endgenerate

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) pipe_busy = pipe_busy | pipe_valid_reg[i];
  end

  assign avs_s0_readdatavalid = pipe_valid_reg[READ_LATENCY-1];
  assign avs_s0_readdata      = pipe_valid_reg[READ_LATENCY-1] ? pipe_data_reg[READ_LATENCY-1] : 32'h0;
`else
  assign pipe_busy       = 1'b0;
  assign avs_s0_readdata = accept_rd ? mem_rdata : 32'h0;
`endif

  assign avs_s0_waitrequest = (state_reg != S_ACCEPT);
  assign protocol_error     = err_reg;
  assign status             = {err_reg, 4'b0000, pipe_busy, state_reg};

endmodule
